// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic datapath blocks.
//   mul_state_e    : sequencing states of the shift-add multiplier
//   MUL_WIDTH      : operand width of the multiplier (fixed by the 4-bit adder)
//   MUL_ITERATIONS : shift-add steps per multiply
//   PRODUCT_WIDTH  : width of the full unsigned product
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int MUL_WIDTH      = 4;
    localparam int MUL_ITERATIONS = 4;
    localparam int PRODUCT_WIDTH  = 2 * MUL_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ripple_adder_4bit_structural.sv
// ---------------------------------------------------------------------------
// ripple_adder_4bit_structural
// 4-bit ripple-carry adder built from gate-level full-adder cells.
// Ports:
//   a, b      [3:0] in  : addends
//   carry_in        in  : carry into bit 0
//   sum       [3:0] out : a + b + carry_in, low four bits
//   carry_out       out : carry out of bit 3
// ---------------------------------------------------------------------------
module ripple_adder_4bit_structural (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    wire [4:0] carry;
    wire [3:0] half_sum;
    wire [3:0] gen;
    wire [3:0] prop;

    assign carry[0] = carry_in;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            xor u_x1 (half_sum[i], a[i], b[i]);
            xor u_x2 (sum[i], half_sum[i], carry[i]);
            and u_a1 (gen[i], a[i], b[i]);
            and u_a2 (prop[i], half_sum[i], carry[i]);
            or  u_o1 (carry[i+1], gen[i], prop[i]);
        end
    endgenerate

    assign carry_out = carry[4];

endmodule

// File: rtl/shift_add_multiplier_4bit.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_4bit
// Sequential 4x4 unsigned multiplier: four shift-add iterations through the
// structural ripple adder, one iteration per clock.
// Ports:
//   clk            in  : rising-edge clock
//   rst_n          in  : synchronous active-low reset
//   start          in  : multiply request, sampled only in IDLE
//   a        [3:0] in  : multiplicand, captured on accepted start
//   b        [3:0] in  : multiplier, captured on accepted start
//   busy           out : high while iterating (RUN)
//   done           out : one-cycle pulse when product is updated
//   product  [7:0] out : last completed a*b, held between operations
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one shift-add per edge, four edges total
// DONE  | product valid, done pulse; returns to IDLE unconditionally
// ---------------------------------------------------------------------------
module shift_add_multiplier_4bit
    import arith_pkg::*;
#(
    parameter int WIDTH      = MUL_WIDTH,
    parameter int ITERATIONS = MUL_ITERATIONS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    generate
        if (WIDTH != 4 || ITERATIONS != WIDTH) begin : g_param_check
            $error("shift_add_multiplier_4bit supports only WIDTH=4, ITERATIONS=4");
        end
    endgenerate

    localparam logic [1:0] CNT_LAST = 2'(ITERATIONS - 1);

    mul_state_e state_q, state_d;

    logic [3:0] m_q;
    logic [3:0] acc_q;
    logic [3:0] q_q;
    logic [1:0] cnt_q;
    logic [7:0] product_q;

    logic       load_ops;
    logic       shift_en;
    logic       load_product;

    logic [3:0] add_sum;
    logic       add_cout;
    logic [4:0] partial;
    logic [3:0] acc_next;
    logic [3:0] q_next;

    ripple_adder_4bit_structural u_adder (
        .a         (acc_q),
        .b         (m_q),
        .carry_in  (1'b0),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    // The adder carry is kept as bit 4 of the partial sum so the top bit of
    // each step lands in acc[3] after the shift instead of being lost.
    always_comb begin
        partial  = q_q[0] ? {add_cout, add_sum} : {1'b0, acc_q};
        acc_next = partial[4:1];
        q_next   = {partial[0], q_q[3:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = IDLE;
        busy         = 1'b0;
        done         = 1'b0;
        load_ops     = 1'b0;
        shift_en     = 1'b0;
        load_product = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_ops = 1'b1;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    load_product = 1'b1;
                    state_d      = DONE;
                end else begin
                    state_d      = RUN;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            if (load_ops) begin
                m_q   <= a;
                q_q   <= b;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (shift_en) begin
                acc_q <= acc_next;
                q_q   <= q_next;
                cnt_q <= cnt_q + 2'd1;
            end
            if (load_product) begin
                product_q <= {acc_next, q_next};
            end
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier_4bit.sv
module tb_shift_add_multiplier_4bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int errors = 0;
    int checks = 0;
    logic [7:0] prev_prod;

    shift_add_multiplier_4bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one multiply, then walks RUN x4, DONE, IDLE checking the
    // handshake. Operands are scrambled after acceptance to show they are
    // not re-sampled.
    task automatic run_mul(input logic [3:0] av, input logic [3:0] bv,
                           input logic [7:0] exp, input string tag);
        a = av;
        b = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        a = ~av;
        b = ~bv;
        for (int k = 1; k <= 4; k++) begin
            check({tag, "_run_busy"}, {7'd0, busy}, 8'd1);
            check({tag, "_run_done"}, {7'd0, done}, 8'd0);
            check({tag, "_run_hold"}, product, prev_prod);
            step();
        end
        check({tag, "_done"}, {7'd0, done}, 8'd1);
        check({tag, "_done_busy"}, {7'd0, busy}, 8'd0);
        check({tag, "_product"}, product, exp);
        step();
        check({tag, "_idle_done"}, {7'd0, done}, 8'd0);
        check({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
        check({tag, "_held"}, product, exp);
        prev_prod = exp;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;
        prev_prod = 8'h00;
        step();
        step();
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        check("reset_product", product, 8'h00);
        rst_n = 1'b1;
        step();

        run_mul(4'd13, 4'd11, 8'h8F, "m13x11");
        run_mul(4'd15, 4'd15, 8'hE1, "m15x15");
        run_mul(4'd0,  4'd9,  8'h00, "m0x9");
        run_mul(4'd7,  4'd0,  8'h00, "m7x0");

        // start re-asserted during RUN must be ignored
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_run1_busy", {7'd0, busy}, 8'd1);
        step();
        start = 1'b1;
        a = 4'd15;
        b = 4'd15;
        check("ign_run2_busy", {7'd0, busy}, 8'd1);
        step();
        check("ign_run3_busy", {7'd0, busy}, 8'd1);
        step();
        check("ign_run4_busy", {7'd0, busy}, 8'd1);
        check("ign_run4_done", {7'd0, done}, 8'd0);
        step();
        start = 1'b0;
        check("ign_done", {7'd0, done}, 8'd1);
        check("ign_product", product, 8'h0F);
        step();
        check("ign_idle_done", {7'd0, done}, 8'd0);
        check("ign_idle_busy", {7'd0, busy}, 8'd0);
        step();
        check("ign_noqueue_busy", {7'd0, busy}, 8'd0);
        check("ign_noqueue_done", {7'd0, done}, 8'd0);
        check("ign_held", product, 8'h0F);

        // reset in RUN cycle 3
        a = 4'd9;
        b = 4'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("rst_pre_busy", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_product", product, 8'h00);
        step();
        check("rst_after_done", {7'd0, done}, 8'd0);
        check("rst_after_busy", {7'd0, busy}, 8'd0);
        prev_prod = 8'h00;
        run_mul(4'd2, 4'd3, 8'h06, "m2x3");

        // start held: one multiply every 6 cycles, done at k = 4, 10, 16
        a = 4'd12;
        b = 4'd10;
        start = 1'b1;
        step();
        for (int k = 1; k <= 18; k++) begin
            step();
            check($sformatf("b2b_done_k%0d", k), {7'd0, done},
                  {7'd0, (k == 4 || k == 10 || k == 16)});
            check($sformatf("b2b_busy_k%0d", k), {7'd0, busy},
                  {7'd0, ((k % 6) < 4)});
            check($sformatf("b2b_prod_k%0d", k), product, (k < 4) ? 8'h06 : 8'h78);
        end
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier_4bit.md
Name: shift_add_multiplier_4bit

Overview:
- Sequential 4x4 unsigned multiplier built around the existing 4-bit structural ripple adder.
- Captures two operands on a start handshake and runs four shift-add iterations.
- Each iteration feeds the adder its operands and consumes the adder's sum and carry.
- Presents an 8-bit product with a one-cycle done pulse; first sequential consumer of the adder in the arithmetic datapath.

Parameters:
- WIDTH, 4, operand width. Only 4 is supported because the adder is fixed-width; the parameter exists for self-documentation and assertions.
- ITERATIONS, 4, shift-add steps per multiply. Must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  4  multiplicand; captured when start is accepted.
- b  input  4  multiplier; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the product becomes valid.
- product  output  8  unsigned a*b; holds the last result.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low. While rst_n=0 at a rising edge: state=IDLE, busy=0, done=0, product=8'h00, internal M/acc/q/cnt/carry all cleared.
- Registers:
  - M[3:0]: multiplicand.
  - acc[3:0]: partial high half.
  - q[3:0]: multiplier, becomes the low half.
  - cnt[1:0]: iteration counter.
- State machine:
  - IDLE: busy=0, done=0. If start=1 at an edge: M<=a, q<=b, acc<=0, cnt<=0, go to RUN. Otherwise stay.
  - RUN: busy=1, done=0. Adder inputs are a=acc, b=M, carry_in=0. Each edge:
    - If q[0]=1: {c,s} = {carry_out,sum}.
    - If q[0]=0: {c,s} = {0,acc}.
    - Update the 9-bit shift {acc,q} <= {c,s,q} >> 1, i.e. acc<={c,s[3:1]} and q<={s[0],q[3:1]}.
    - cnt<=cnt+1. On the edge where cnt==3, also load product<={new acc,new q} and go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- Latency: start accepted at edge N; RUN edges N+1..N+4; product valid and done=1 after edge N+4. A new start is accepted no earlier than edge N+6 (IDLE entered after N+5).
- Back-to-back: holding start=1 continuously produces one multiply every 6 cycles.
- start asserted during RUN or DONE: ignored. No queuing, captured operands unchanged.
- Operand changes on a/b after acceptance have no effect.
- product changes only at a completion edge (or reset); it holds between operations.
- Width rule: the adder carry is the 5th bit of each partial sum and is never dropped. The maximum 15*15=225 fits 8 bits; overflow is impossible.
- Reset mid-operation (rst_n=0 during RUN or DONE): immediate return to reset values at that edge. No done pulse; product cleared to 0.
- Illegal state encodings decode to IDLE.

Decomposition:
- Shared package `arith_pkg`:
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constants MUL_WIDTH=4, MUL_ITERATIONS=4.
  - PRODUCT_WIDTH=2*MUL_WIDTH.
- One sub-module instance: ripple_adder_4bit_structural (existing, unmodified) as the datapath adder, with carry_in tied to 0. FSM, shift register and counter stay in this module; no new sub-module.

Test Plan:
- Reset, then a=13, b=11, start pulse -> busy=1 for 4 cycles; done=1 on the 5th cycle after acceptance; product=8'h8F (143), held afterwards.
- a=15, b=15 -> product=8'hE1 (225). Checks carry_out propagation through every iteration.
- a=0, b=9 and a=7, b=0 -> product=8'h00 both times; done still pulses once each.
- Start accepted with a=3, b=5; at RUN cycle 2 drive start=1 with a=15, b=15 -> ignored; product=8'h0F; exactly one done pulse.
- Start a=9, b=6; assert rst_n=0 at RUN cycle 3 -> next cycle busy=0, done=0, product=0, state IDLE. Then a=2, b=3 -> product=8'h06.
- start held high with a=12, b=10 -> products of 8'h78 every 6 cycles; done pulses spaced exactly 6 cycles apart.
